hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's combinational load-use hazard unit.
- Per-register countdown scoreboard in the ID stage.
- Handles configurable load latency, a multi-cycle non-pipelined multiplier, and taken-branch flush.
- Drives the same stall controls as before (pc_write, if_id_write, control_dst), plus if_id_flush.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Groups the ID-stage instruction fields and the stall/flush controls
// exchanged between the pipeline and the hazard scoreboard.
//   master : pipeline side. It drives the ID fields and branch_taken, and it
//            receives pc_write, if_id_write, control_dst, if_id_flush and
//            stall_cycles.
//   slave  : scoreboard side. The directions are the mirror image of master.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              rs_used;
  logic              rt_used;
  logic              id_valid;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic [1:0]        id_kind;
  logic              branch_taken;
  logic              pc_write;
  logic              if_id_write;
  logic              control_dst;
  logic              if_id_flush;
  logic [15:0]       stall_cycles;

  modport master (
    output if_id_rs, if_id_rt, rs_used, rt_used, id_valid,
           id_dst, id_regwrite, id_kind, branch_taken,
    input  pc_write, if_id_write, control_dst, if_id_flush, stall_cycles
  );

  modport slave (
    input  if_id_rs, if_id_rt, rs_used, rt_used, id_valid,
           id_dst, id_regwrite, id_kind, branch_taken,
    output pc_write, if_id_write, control_dst, if_id_flush, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// This is the ID-stage countdown scoreboard. Each architectural register has
// a count of the cycles left until its pending result can be forwarded. A
// separate busy count covers the non-pipelined multiplier. From these counts
// the block derives the stall and flush controls for the front of the pipe.
//
// Ports:
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset. It clears every count and the
//           perf counter.
//   bus   : hazard_scoreboard_if.slave. It carries the ID fields in and the
//           pc_write / if_id_write / control_dst / if_id_flush /
//           stall_cycles outputs.
//
// Optional feature macro: HAZ_STALL_CNT_EN
//   Defined   : stall_cycles counts the stalled cycles and saturates at
//               16'hFFFF.
//   Undefined : stall_cycles is tied to 16'd0.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  logic [CNT_W-1:0] cnt_r [NREG];
  logic [CNT_W-1:0] mul_busy_r;

  logic             raw_s;
  logic             struct_s;
  logic             stall_s;
  logic             issue_s;
  logic             set_s;
  logic [CNT_W-1:0] set_val_s;

  // Hazard detection. Register 0 is never tracked, so reads of it never
  // stall.
  always_comb begin
    raw_s = 1'b0;
    if ((bus.rs_used && (bus.if_id_rs != {REG_AW{1'b0}}) && (cnt_r[bus.if_id_rs] != {CNT_W{1'b0}})) ||
        (bus.rt_used && (bus.if_id_rt != {REG_AW{1'b0}}) && (cnt_r[bus.if_id_rt] != {CNT_W{1'b0}}))) begin
      raw_s = 1'b1;
    end else begin
      raw_s = 1'b0;
    end
    struct_s = bus.id_valid && (bus.id_kind == 2'd2) && (mul_busy_r != {CNT_W{1'b0}});
    stall_s  = bus.id_valid && (raw_s || struct_s) && !bus.branch_taken;
    issue_s  = bus.id_valid && !stall_s && !bus.branch_taken;
    set_s    = issue_s && bus.id_regwrite && (bus.id_dst != {REG_AW{1'b0}});
  end

  // Latency loaded into the destination entry. ALU results are forwarded,
  // so an ALU write needs no wait. The reserved kind is handled as ALU.
  always_comb begin
    set_val_s = {CNT_W{1'b0}};
    case (bus.id_kind)
      2'd1:    set_val_s = CNT_W'(LOAD_LAT);
      2'd2:    set_val_s = CNT_W'(MUL_LAT);
      default: set_val_s = {CNT_W{1'b0}};
    endcase
  end

  // Per-register countdowns. A new issue overrides the decrement of the same
  // entry, so the newest producer always defines the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt_r[r] <= {CNT_W{1'b0}};
        end else if (set_s && (bus.id_dst == REG_AW'(r))) begin
          cnt_r[r] <= set_val_s;
        end else if (cnt_r[r] != {CNT_W{1'b0}}) begin
          cnt_r[r] <= cnt_r[r] - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Multiplier occupancy. A flush does not cancel it, because the multiply
  // in flight still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy_r <= {CNT_W{1'b0}};
    end else if (issue_s && (bus.id_kind == 2'd2)) begin
      mul_busy_r <= CNT_W'(MUL_LAT);
    end else if (mul_busy_r != {CNT_W{1'b0}}) begin
      mul_busy_r <= mul_busy_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mul_busy_r <= mul_busy_r;
    end
  end

  // Front-end controls. The priority is branch, then stall, then normal.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.control_dst = 1'b0;
    bus.if_id_flush = 1'b0;
    if (bus.branch_taken) begin
      bus.pc_write    = 1'b1;
      bus.if_id_write = 1'b1;
      bus.control_dst = 1'b1;
      bus.if_id_flush = 1'b1;
    end else if (stall_s) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.control_dst = 1'b1;
      bus.if_id_flush = 1'b0;
    end else begin
      bus.pc_write    = 1'b1;
      bus.if_id_write = 1'b1;
      bus.control_dst = 1'b0;
      bus.if_id_flush = 1'b0;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled cycles. Flush cycles never assert stall_s,
  // so they are excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cycles = stall_cnt_r;
`else
  assign bus.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// This bench runs the directed scenarios and then randomized ID-stage traffic.
// The results are compared against a timeline model. The model stores, for
// each register, the cycle from which the register can be consumed. It also
// stores the cycle from which the multiplier is free.
module tb_hazard_scoreboard;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 4;
  localparam int CNT_W    = 3;
  localparam int NREG     = 2 ** REG_AW;

  logic clk;
  logic rst_n;

  hazard_scoreboard_if #(.REG_AW(REG_AW)) bus ();

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .LOAD_LAT(LOAD_LAT),
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference timeline.
  longint cyc;
  longint ready_at [NREG];
  longint mul_free_at;
  int     stall_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint lat_of(input logic [1:0] kind);
    case (kind)
      2'd1:    return LOAD_LAT;
      2'd2:    return MUL_LAT;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    mul_free_at = 0;
    stall_cnt   = 0;
  endtask

  function automatic logic [15:0] exp_stall_cycles();
`ifdef HAZ_STALL_CNT_EN
    return 16'(stall_cnt);
`else
    return 16'd0;
`endif
  endfunction

  task automatic drive(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic rsu, input logic rtu, input logic v,
                       input logic [REG_AW-1:0] dst, input logic rw,
                       input logic [1:0] kind, input logic br);
    bus.if_id_rs     = rs;
    bus.if_id_rt     = rt;
    bus.rs_used      = rsu;
    bus.rt_used      = rtu;
    bus.id_valid     = v;
    bus.id_dst       = dst;
    bus.id_regwrite  = rw;
    bus.id_kind      = kind;
    bus.branch_taken = br;
  endtask

  // Called 1 time unit after a rising edge. It checks the outputs at the
  // falling edge, advances the model, and then crosses the next rising edge.
  task automatic step(input string tag);
    logic raw, strct, stall, issue;
    logic [3:0] exp_ctl;
    @(negedge clk);
    raw = (bus.rs_used && bus.if_id_rs != 0 && cyc < ready_at[bus.if_id_rs]) ||
          (bus.rt_used && bus.if_id_rt != 0 && cyc < ready_at[bus.if_id_rt]);
    strct = bus.id_valid && bus.id_kind == 2'd2 && cyc < mul_free_at;
    stall = bus.id_valid && (raw || strct) && !bus.branch_taken;
    if (bus.branch_taken) exp_ctl = 4'b1111;
    else if (stall)       exp_ctl = 4'b0010;
    else                  exp_ctl = 4'b1100;
    chk_eq({tag, ".ctl"}, {28'd0, bus.pc_write, bus.if_id_write, bus.control_dst, bus.if_id_flush},
           {28'd0, exp_ctl});
    chk_eq({tag, ".stall_cycles"}, {16'd0, bus.stall_cycles}, {16'd0, exp_stall_cycles()});
    issue = bus.id_valid && !stall && !bus.branch_taken;
    if (issue && bus.id_regwrite && bus.id_dst != 0)
      ready_at[bus.id_dst] = cyc + 1 + lat_of(bus.id_kind);
    if (issue && bus.id_kind == 2'd2)
      mul_free_at = cyc + 1 + MUL_LAT;
    if (stall && stall_cnt < 65535) stall_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input string tag);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    step(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    #2;
    chk_eq("reset.ctl", {28'd0, bus.pc_write, bus.if_id_write, bus.control_dst, bus.if_id_flush},
           32'h0000_000C);
    chk_eq("reset.stall_cycles", {16'd0, bus.stall_cycles}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: ALU producer, then its consumer. Forwarding means no stall.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd0, 1'b0); step("t1.alu");
    drive(5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 2'd0, 1'b0); step("t1.use");
    idle("t1.idle");

    // 2: Load, then its consumer. The consumer stalls for one cycle.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd1, 1'b0); step("t2.ld");
    drive(5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) step("t2.use");
    idle("t2.idle");

    // 3: Mul, then its consumer. A second mul then hits the structural
    // hazard.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 2'd2, 1'b0); step("t3.mul");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) step("t3.use");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 2'd2, 1'b0); step("t3.mul_a");
    drive(5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) step("t3.mul_b");
    for (int i = 0; i < 5; i++) idle("t3.idle");

    // 4: Load to register 0. Readers of register 0 never stall.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 2'd1, 1'b0); step("t4.ld0");
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 2'd0, 1'b0); step("t4.use0");
    idle("t4.idle");

    // 5: Branch while a consumer is stalled on a mul. The countdown keeps
    // running.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 2'd2, 1'b0); step("t5.mul");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0); step("t5.stall");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b1); step("t5.branch");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step("t5.after");
    for (int i = 0; i < 4; i++) idle("t5.idle");

    // 6: Reset during the second cycle of a mul stall.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 2'd2, 1'b0); step("t6.mul");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0); step("t6.stall1");
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6.rst.ctl", {28'd0, bus.pc_write, bus.if_id_write, bus.control_dst, bus.if_id_flush},
           32'h0000_000C);
    chk_eq("t6.rst.stall_cycles", {16'd0, bus.stall_cycles}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    step("t6.after_rst");
    idle("t6.idle");

    // Randomized traffic on a narrow register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 7)), 1'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
